// File: rtl/weight_store_pkg.sv
// Shared types and widths for the per-layer weight store.
package weight_store_pkg;

  localparam int DEF_NEURON_NUM        = 5;
  localparam int DEF_WEIGHT_CELL_WIDTH = 16;
  localparam int DEF_MAT_W             = DEF_NEURON_NUM * DEF_NEURON_NUM * DEF_WEIGHT_CELL_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE   = 2'd1,
    ST_WAIT_WB = 2'd2
  } state_t;

  function automatic int mat_width(input int neuron_num, input int cell_width);
    return neuron_num * neuron_num * cell_width;
  endfunction

endpackage

// File: rtl/weight_store_bank.sv
// Register array of weight matrices: one write port, one combinational read (w) and one registered read (rd_w).
// Out-of-range addresses read as zero and never write; o_wr_oor flags a rejected write.
module weight_bank
  import weight_store_pkg::*;
#(
  parameter int LAYER_NUM        = 3,
  parameter int LAYER_ADDR_WIDTH = 2,
  parameter int MAT_W            = DEF_MAT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_wr_en,
  input  logic [LAYER_ADDR_WIDTH-1:0] i_wr_layer,
  input  logic [MAT_W-1:0]            i_wr_data,
  input  logic [LAYER_ADDR_WIDTH-1:0] i_w_layer,
  output logic [MAT_W-1:0]            o_w,
  input  logic [LAYER_ADDR_WIDTH-1:0] i_rd_layer,
  output logic [MAT_W-1:0]            o_rd_w,
  output logic                        o_wr_oor
);

  logic [MAT_W-1:0] r_bank [LAYER_NUM];
  logic [MAT_W-1:0] r_rd_w;
  logic [MAT_W-1:0] w_rd_sel;
  logic [MAT_W-1:0] w_w_sel;

  // Select by equality so an index past LAYER_NUM falls through to zero.
  always_comb begin
    w_rd_sel = '0;
    w_w_sel  = '0;
    for (int l = 0; l < LAYER_NUM; l++) begin
      if (int'(i_rd_layer) == l) w_rd_sel = r_bank[l];
      if (int'(i_w_layer) == l)  w_w_sel  = r_bank[l];
    end
  end

  assign o_w      = w_w_sel;
  assign o_rd_w   = r_rd_w;
  assign o_wr_oor = i_wr_en && (int'(i_wr_layer) >= LAYER_NUM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < LAYER_NUM; l++) r_bank[l] <= '0;
      r_rd_w <= '0;
    end else begin
      for (int l = 0; l < LAYER_NUM; l++) begin
        if (i_wr_en && int'(i_wr_layer) == l) r_bank[l] <= i_wr_data;
      end
      r_rd_w <= w_rd_sel;
    end
  end

endmodule

// File: rtl/weight_store.sv
// Per-layer weight store: serves a locked layer on w, commits the updated matrix from result,
// and offers a load port plus a 1-cycle registered forward read port.
module weight_store
  import weight_store_pkg::*;
#(
  parameter int LAYER_NUM         = 3,
  parameter int LAYER_ADDR_WIDTH  = 2,
  parameter int NEURON_NUM        = 5,
  parameter int WEIGHT_CELL_WIDTH = 16,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [LAYER_ADDR_WIDTH-1:0]                        req_layer,
  input  logic                                               req_valid,
  output logic                                               req_ready,
  output logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0] w,
  output logic                                               w_valid,
  input  logic                                               w_ready,
  input  logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0] result,
  input  logic                                               result_valid,
  output logic                                               result_ready,
  input  logic [LAYER_ADDR_WIDTH-1:0]                        load_layer,
  input  logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0] load_data,
  input  logic                                               load_valid,
  output logic                                               load_ready,
  input  logic [LAYER_ADDR_WIDTH-1:0]                        rd_layer,
  output logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0] rd_w,
  output logic [COUNT_WIDTH-1:0]                             update_count,
  output logic                                               error
);

  localparam int MAT_W = mat_width(NEURON_NUM, WEIGHT_CELL_WIDTH);

  state_t                      r_state;
  state_t                      w_nxt_state;
  logic [LAYER_ADDR_WIDTH-1:0] r_locked;
  logic [COUNT_WIDTH-1:0]      r_count;

  logic w_req_rdy, w_load_rdy, w_w_vld, w_res_rdy;
  logic w_req_hs, w_load_hs, w_w_hs, w_res_hs;
  logic w_req_in_range;
  logic w_wr_en;
  logic w_wr_oor;
  logic [LAYER_ADDR_WIDTH-1:0] w_wr_layer;
  logic [MAT_W-1:0]            w_wr_data;

  always_comb begin
    w_nxt_state = r_state;
    w_req_rdy   = 1'b0;
    w_load_rdy  = 1'b0;
    w_w_vld     = 1'b0;
    w_res_rdy   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_load_rdy = 1'b1;
        // A same-cycle load wins; the request stays pending for the next cycle.
        w_req_rdy  = !load_valid;
        if (req_valid && !load_valid && w_req_in_range) w_nxt_state = ST_SERVE;
      end
      ST_SERVE: begin
        w_w_vld = 1'b1;
        if (w_ready) w_nxt_state = ST_WAIT_WB;
      end
      ST_WAIT_WB: begin
        w_res_rdy = 1'b1;
        if (result_valid) w_nxt_state = ST_IDLE;
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  assign w_req_in_range = int'(req_layer) < LAYER_NUM;

  assign req_ready    = !rst && w_req_rdy;
  assign load_ready   = !rst && w_load_rdy;
  assign w_valid      = !rst && w_w_vld;
  assign result_ready = !rst && w_res_rdy;

  assign w_req_hs  = req_valid && req_ready;
  assign w_load_hs = load_valid && load_ready;
  assign w_w_hs    = w_valid && w_ready;
  assign w_res_hs  = result_valid && result_ready;

  // Load and commit are mutually exclusive by state, so one write port suffices.
  assign w_wr_en    = w_load_hs || w_res_hs;
  assign w_wr_layer = w_res_hs ? r_locked : load_layer;
  assign w_wr_data  = w_res_hs ? result : load_data;

  assign error = !rst && (w_wr_oor
                          || (w_req_hs && !w_req_in_range)
                          || (result_valid && r_state != ST_WAIT_WB));

  assign update_count = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_locked <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_nxt_state;
      if (w_req_hs && w_req_in_range) r_locked <= req_layer;
      if (w_res_hs)                   r_count  <= r_count + 1'b1;
    end
  end

  weight_bank #(
    .LAYER_NUM        (LAYER_NUM),
    .LAYER_ADDR_WIDTH (LAYER_ADDR_WIDTH),
    .MAT_W            (MAT_W)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_wr_en),
    .i_wr_layer (w_wr_layer),
    .i_wr_data  (w_wr_data),
    .i_w_layer  (r_locked),
    .o_w        (w),
    .i_rd_layer (rd_layer),
    .o_rd_w     (rd_w),
    .o_wr_oor   (w_wr_oor)
  );

  logic w_unused;
  assign w_unused = w_w_hs;

endmodule

// File: tb/tb_weight_store.sv
// Randomized bench for weight_store against a transaction-level model of banks and commit count.
module tb_weight_store;

  localparam int LN = 3;
  localparam int AW = 2;
  localparam int NN = 5;
  localparam int CW = 16;
  localparam int UW = 2;
  localparam int MW = NN * NN * CW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] req_layer, load_layer, rd_layer;
  logic          req_valid, req_ready;
  logic [MW-1:0] w, result, load_data, rd_w;
  logic          w_valid, w_ready, result_valid, result_ready, load_valid, load_ready;
  logic [UW-1:0] update_count;
  logic          error;

  weight_store #(
    .LAYER_NUM(LN), .LAYER_ADDR_WIDTH(AW), .NEURON_NUM(NN),
    .WEIGHT_CELL_WIDTH(CW), .COUNT_WIDTH(UW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_layer(req_layer), .req_valid(req_valid), .req_ready(req_ready),
    .w(w), .w_valid(w_valid), .w_ready(w_ready),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .load_layer(load_layer), .load_data(load_data), .load_valid(load_valid), .load_ready(load_ready),
    .rd_layer(rd_layer), .rd_w(rd_w), .update_count(update_count), .error(error)
  );

  always #5 clk = ~clk;

  logic [MW-1:0] m_bank [LN];
  int            m_count;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] fill(input logic [CW-1:0] v);
    logic [MW-1:0] m;
    for (int i = 0; i < NN * NN; i++) m[i*CW +: CW] = v;
    return m;
  endfunction

  function automatic logic [MW-1:0] rnd_mat();
    logic [MW-1:0] m;
    for (int i = 0; i < NN * NN; i++) m[i*CW +: CW] = CW'($urandom);
    return m;
  endfunction

  function automatic logic [MW-1:0] exp_rd(input int l);
    return (l < LN) ? m_bank[l] : '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int l = 0; l < LN; l++) m_bank[l] = '0;
    m_count = 0;
  endtask

  task automatic check_read(input int l);
    rd_layer = AW'(l);
    tick();
    chk("rd_w", rd_w, exp_rd(l));
  endtask

  task automatic do_load(input int l, input logic [MW-1:0] d);
    load_layer = AW'(l);
    load_data  = d;
    load_valid = 1'b1;
    #1;
    chk("load_ready", MW'(load_ready), MW'(1));
    chk("load_err", MW'(error), MW'(l >= LN));
    tick();
    load_valid = 1'b0;
    if (l < LN) m_bank[l] = d;
  endtask

  task automatic do_update(input int l, input logic [MW-1:0] d, input int wd, input int rdl);
    logic [MW-1:0] old;
    req_layer = AW'(l);
    req_valid = 1'b1;
    #1;
    chk("req_ready", MW'(req_ready), MW'(1));
    chk("req_err", MW'(error), MW'(l >= LN));
    tick();
    req_valid = 1'b0;
    #1;
    if (l >= LN) begin
      chk("oor_stay_idle", MW'(w_valid), MW'(0));
      chk("oor_req_ready", MW'(req_ready), MW'(1));
    end else begin
      old      = m_bank[l];
      rd_layer = AW'(l);
      repeat (wd) begin
        w_ready = 1'b0;
        #1;
        chk("stall_w_valid", MW'(w_valid), MW'(1));
        chk("stall_w", w, old);
        chk("serve_load_ready", MW'(load_ready), MW'(0));
        chk("serve_req_ready", MW'(req_ready), MW'(0));
        tick();
      end
      w_ready = 1'b1;
      #1;
      chk("w_valid", MW'(w_valid), MW'(1));
      chk("w", w, old);
      tick();
      w_ready = 1'b0;
      repeat (rdl) begin
        #1;
        chk("wb_result_ready", MW'(result_ready), MW'(1));
        chk("wb_load_ready", MW'(load_ready), MW'(0));
        chk("wb_req_ready", MW'(req_ready), MW'(0));
        chk("wb_rd_old", rd_w, old);
        tick();
      end
      result       = d;
      result_valid = 1'b1;
      #1;
      chk("result_ready", MW'(result_ready), MW'(1));
      chk("commit_err", MW'(error), MW'(0));
      tick();
      result_valid = 1'b0;
      #1;
      chk("rd_at_commit", rd_w, old);
      m_bank[l] = d;
      m_count++;
      chk("update_count", MW'(update_count), MW'(m_count % (1 << UW)));
      chk("idle_req_ready", MW'(req_ready), MW'(1));
      tick();
      chk("rd_after_commit", rd_w, d);
    end
  endtask

  task automatic stray_result();
    result       = rnd_mat();
    result_valid = 1'b1;
    #1;
    chk("stray_err", MW'(error), MW'(1));
    chk("stray_result_ready", MW'(result_ready), MW'(0));
    tick();
    result_valid = 1'b0;
    for (int l = 0; l < LN; l++) check_read(l);
  endtask

  initial begin
    logic [MW-1:0] d;
    int            lc;
    rst = 1'b1;
    req_layer = '0; load_layer = '0; rd_layer = '0;
    result = '0; load_data = '0; w_ready = 1'b1;
    req_valid = 1'b1; load_valid = 1'b1; result_valid = 1'b1;
    model_reset();
    repeat (2) tick();
    chk("rst_req_ready", MW'(req_ready), MW'(0));
    chk("rst_load_ready", MW'(load_ready), MW'(0));
    chk("rst_w_valid", MW'(w_valid), MW'(0));
    chk("rst_result_ready", MW'(result_ready), MW'(0));
    chk("rst_error", MW'(error), MW'(0));
    req_valid = 1'b0; load_valid = 1'b0; result_valid = 1'b0; w_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int l = 0; l <= LN; l++) check_read(l);
    chk("rst_count", MW'(update_count), MW'(0));

    // Directed: load then update layer 1
    do_load(1, fill(16'h0010));
    do_update(1, fill(16'h0011), 0, 0);
    check_read(0);
    check_read(2);

    // Backpressure on w and on result
    do_update(1, fill(16'h0012), 5, 3);

    // Collision: load and request in the same IDLE cycle
    lc = 2;
    d  = rnd_mat();
    load_layer = AW'(lc); load_data = d; load_valid = 1'b1;
    req_layer  = AW'(lc); req_valid = 1'b1;
    #1;
    chk("coll_req_ready", MW'(req_ready), MW'(0));
    chk("coll_load_ready", MW'(load_ready), MW'(1));
    tick();
    load_valid = 1'b0;
    m_bank[lc] = d;
    #1;
    chk("coll_req_ready_next", MW'(req_ready), MW'(1));
    tick();
    req_valid = 1'b0;
    #1;
    chk("coll_w_valid", MW'(w_valid), MW'(1));
    chk("coll_w", w, d);
    w_ready = 1'b1;
    tick();
    w_ready = 1'b0;
    d = rnd_mat();
    result = d; result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    m_bank[lc] = d;
    m_count++;
    check_read(lc);

    // Range errors and stray result
    do_update(3, '0, 0, 0);
    do_load(3, rnd_mat());
    for (int l = 0; l < LN; l++) check_read(l);
    stray_result();

    // Reset while waiting for write-back
    req_layer = '0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; w_ready = 1'b1;
    tick();
    w_ready = 1'b0;
    #1;
    chk("pre_rst_result_ready", MW'(result_ready), MW'(1));
    rst = 1'b1;
    #1;
    chk("midrst_result_ready", MW'(result_ready), MW'(0));
    chk("midrst_load_ready", MW'(load_ready), MW'(0));
    model_reset();
    tick();
    rst = 1'b0;
    chk("midrst_count", MW'(update_count), MW'(0));
    for (int l = 0; l < LN; l++) check_read(l);

    // Counter wrap: four commits from reset
    for (int i = 0; i < 4; i++) do_update(i % LN, rnd_mat(), 0, 0);
    chk("count_wrap", MW'(update_count), MW'(0));

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: do_load($urandom_range(0, LN), rnd_mat());
        1: do_update($urandom_range(0, LN), rnd_mat(), $urandom_range(0, 3), $urandom_range(0, 3));
        2: stray_result();
        default: check_read($urandom_range(0, LN));
      endcase
    end
    for (int l = 0; l <= LN; l++) check_read(l);
    chk("final_count", MW'(update_count), MW'(m_count % (1 << UW)));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_store.md
Name: weight_store

Overview:
- Per-layer weight bank for the layer-multiplexed network. It is the supplier and consumer of the weight updater's `w` and `result` streams.
- On a layer request it presents that layer's weight matrix on `w` with valid/ready. It then accepts the updated matrix back on `result` and commits it.
- It also gives the forward path a registered read port and a load port for initial weights.

Parameters:
- LAYER_NUM, 3, number of weight layers stored.
- LAYER_ADDR_WIDTH, 2, width of layer indices; must satisfy 2**LAYER_ADDR_WIDTH >= LAYER_NUM.
- NEURON_NUM, 5, neurons per layer; a matrix is NEURON_NUM*NEURON_NUM cells.
- WEIGHT_CELL_WIDTH, 16, width of one weight cell.
- COUNT_WIDTH, 16, width of the committed-update counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_layer  in  LAYER_ADDR_WIDTH  layer whose weights are to be updated.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- w  out  NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH  weights of the locked layer, cell i at [i*WEIGHT_CELL_WIDTH +: WEIGHT_CELL_WIDTH].
- w_valid  out  1  w valid.
- w_ready  in  1  consumer (weight updater) accepts w.
- result  in  NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH  updated weights from the updater.
- result_valid  in  1  result valid.
- result_ready  out  1  result accepted.
- load_layer  in  LAYER_ADDR_WIDTH  layer to overwrite with initial weights.
- load_data  in  NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH  initial weights.
- load_valid  in  1  load valid.
- load_ready  out  1  load accepted.
- rd_layer  in  LAYER_ADDR_WIDTH  forward-path read address.
- rd_w  out  NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH  registered read data.
- update_count  out  COUNT_WIDTH  number of committed write-backs.
- error  out  1  one-cycle pulse on a protocol or range violation.

Behaviour:
- Reset (async, rst=1):
  - All banks, rd_w, update_count and locked layer are cleared to 0; FSM goes to IDLE.
  - All ready/valid outputs and error are 0 while rst is high.
  - A reset mid-transaction discards that transaction; banks stay zero.
- FSM states: IDLE, SERVE, WAIT_WB.
- IDLE:
  - load_ready=1.
  - req_ready = !load_valid (load has priority on a same-cycle collision; the request stays pending).
  - Load handshake: bank[load_layer] <= load_data. If load_layer >= LAYER_NUM, write nothing and pulse error.
  - Request handshake with req_layer < LAYER_NUM: latch the layer, go to SERVE.
  - Request handshake with req_layer >= LAYER_NUM: request consumed, error pulse, stay in IDLE.
- SERVE:
  - w_valid=1; w is driven combinationally from bank[locked].
  - On w_valid && w_ready, go to WAIT_WB.
  - w must not change while w_valid=1.
- WAIT_WB:
  - result_ready=1.
  - On handshake: bank[locked] <= result, update_count += 1 (wraps modulo 2**COUNT_WIDTH), return to IDLE next cycle.
  - Minimum round trip: request accept, then w handshake no earlier than the next cycle, then result handshake; the next request is accepted no earlier than the cycle after the commit.
- Outside WAIT_WB: result_ready=0. result_valid=1 outside WAIT_WB pulses error once per cycle it is asserted; no write.
- load_ready=0 and req_ready=0 in SERVE and WAIT_WB (the bank is locked).
- Read port:
  - rd_w <= bank[rd_layer] every cycle; latency 1.
  - Out-of-range rd_layer returns 0.
  - Reading the locked layer during WAIT_WB returns the pre-update value; a commit becomes visible on rd_w the cycle after the commit edge.
- Arithmetic: no arithmetic on weights; bits are stored verbatim.

Decomposition:
- Shared package: the cell/matrix width localparam (NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH) and the FSM state encoding (IDLE=0, SERVE=1, WAIT_WB=2).
- One sub-module: weight_bank. It is a LAYER_NUM x matrix-width register array with one write port, one combinational port (w) and one registered port (rd_w), and handles in-range checking.
- weight_store holds the FSM, handshakes, counter and error logic.

Test Plan:
- Reset then read: rst pulse; rd_layer=0..2 -> rd_w=0 each cycle after the address; update_count=0; all ready/valid outputs 0 during rst.
- Load then update: load layer 1 with all cells 16'h0010; req_layer=1; w_ready held 1 -> w cells =16'h0010 in SERVE; return result cells 16'h0011 -> rd_w(layer 1)=16'h0011 one cycle after commit; update_count=1; layers 0 and 2 unchanged.
- Backpressure: w_ready=0 for 5 cycles -> w_valid stays 1 with w stable. Then result_valid delayed 3 cycles in WAIT_WB -> req_ready=0 and load_ready=0 throughout.
- Collision and range errors:
  - load_valid and req_valid in the same IDLE cycle -> load commits first, request accepted the next cycle.
  - req_layer=3 -> one-cycle error pulse, FSM stays IDLE.
  - load_layer=3 -> error pulse, no bank change.
- Stray result: result_valid=1 in IDLE -> error=1 that cycle, result_ready=0, banks unchanged.
- Reset mid-operation and counter wrap:
  - rst asserted in WAIT_WB -> next request is accepted normally; banks read 0.
  - With COUNT_WIDTH=2, four commits -> update_count returns to 0.
